// File: rtl/soc_mem_arb_pkg.sv
// Shared types and default widths for the two-master on-chip RAM arbiter.
package soc_mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam int DEF_ADDR_W   = 14;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LOCK_MAX = 64;
  localparam int CNT_W        = 16;

endpackage

// File: rtl/soc_mem_arb_rr2.sv
// Two-way round-robin grant with lock override; prio is the only state here.
module soc_mem_arb_rr2
  import soc_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       locked,
  input  mst_idx_t   owner,
  input  logic       prio_load,
  input  mst_idx_t   prio_val,
  output logic       gnt_valid,
  output mst_idx_t   gnt_idx
);

  mst_idx_t prio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= 1'b0;
    end else if (prio_load) begin
      prio <= prio_val;
    end
  end

  // While locked only the owner can win; the other master waits even if it has priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = prio;
    if (locked) begin
      gnt_valid = req[owner];
      gnt_idx   = owner;
    end else if (req == 2'b11) begin
      gnt_valid = 1'b1;
      gnt_idx   = prio;
    end else if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b0;
    end else if (req[1]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b1;
    end
  end

endmodule

// File: rtl/soc_system_onchip_mem_arbiter.sv
// Arbitrates two Avalon-MM masters onto one single-port RAM with 1-cycle read latency.
// Handshake: a master holds read/write stable; waitrequest low marks the accepting cycle.
module soc_system_onchip_mem_arbiter
  import soc_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  arb_state_t       state, state_nxt;
  mst_idx_t         owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_to;
  logic [1:0]       lock_ign;
  logic             rd_pend;
  mst_idx_t         rd_tag;

  logic [1:0] req, wr, lk;
  logic       gnt_valid, accept, acc_wr, lock_req, owner_rel, force_rel;
  logic       locked, prio_load;
  mst_idx_t   gnt_idx, prio_val;

  assign req = {m1_read | m1_write, m0_read | m0_write};
  assign wr  = {m1_write, m0_write};
  assign lk  = {m1_lock, m0_lock};

  soc_mem_arb_rr2 u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .locked    (locked),
    .owner     (owner),
    .prio_load (prio_load),
    .prio_val  (prio_val),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign accept    = gnt_valid & ~reset_req;
  assign acc_wr    = wr[gnt_idx];
  // A master whose lock timed out cannot re-lock until it finishes an unlocked transfer.
  assign lock_req  = lk[gnt_idx] & ~lock_ign[gnt_idx];
  assign owner_rel = (state == LOCKED) & accept & ~lk[owner];
  assign force_rel = (state == LOCKED) & ~reset_req & (lock_cnt == LOCK_MAX_C) & ~owner_rel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (accept && lock_req) state_nxt = LOCKED;
      LOCKED:  if (owner_rel || force_rel) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    locked    = (state == LOCKED);
    prio_load = 1'b0;
    prio_val  = ~gnt_idx;
    case (state)
      ARB:    prio_load = accept;
      LOCKED: begin
        prio_load = owner_rel | force_rel;
        prio_val  = ~owner;
      end
      default: prio_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= 1'b0;
      lock_cnt <= '0;
      lock_to  <= 1'b0;
      lock_ign <= 2'b00;
    end else begin
      if (state == ARB && state_nxt == LOCKED) begin
        owner    <= gnt_idx;
        lock_cnt <= CNT_W'(1);
      end else if (state == LOCKED && !reset_req && lock_cnt != '1) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
      if (force_rel) begin
        lock_to         <= 1'b1;
        lock_ign[owner] <= 1'b1;
      end
      if (accept && !lk[gnt_idx]) begin
        lock_ign[gnt_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    if (gnt_idx == 1'b1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end else begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end
  end

  assign mem_chipselect = accept;
  assign mem_write      = accept & acc_wr;
  assign mem_clken      = ~reset_req;
  assign m0_waitrequest = ~(accept & (gnt_idx == 1'b0));
  assign m1_waitrequest = ~(accept & (gnt_idx == 1'b1));

  // Read+write together is a write, so only pure reads produce a return beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= accept & ~acc_wr;
      if (accept) rd_tag <= gnt_idx;
    end
  end

  assign m0_readdatavalid = rd_pend & (rd_tag == 1'b0);
  assign m1_readdatavalid = rd_pend & (rd_tag == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: doc/soc_system_onchip_mem_arbiter.md
Name: soc_system_onchip_mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port on-chip RAM (32-bit x 16384 words, byte-enabled, 1-cycle read latency) between two processor-side Avalon-MM masters in the multiprocessor system.
- Round-robin grant, optional per-master lock for atomic read-modify-write, with a lock timeout.
- Sits between the interconnect and the RAM; drives the RAM's address/byteenable/chipselect/write/writedata/clken and returns readdata with readdatavalid.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- LOCK_MAX, 64, maximum consecutive cycles a locked master may hold the grant; range 1..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- reset_req  in  1  high: no new grants; mem_clken low.
- mN_address  in  ADDR_W  word address, N = 0,1.
- mN_byteenable  in  DATA_W/8  byte lanes.
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_writedata  in  DATA_W  write data.
- mN_lock  in  1  keep grant after this transfer.
- mN_waitrequest  out  1  low = transfer accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  readdata valid, exactly one per accepted read.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable = ~reset_req.
- mem_readdata  in  DATA_W  RAM q, valid 1 cycle after read issue.

Behaviour:
- Request: reqN = mN_read | mN_write. Read and write asserted together: treat as write; read ignored.
- Grant is combinational from reqN, the lock state and the priority pointer prio (registered, reset 0).
- Priority:
  - LOCKED to master L: grant L if reqL, else nobody.
  - Otherwise with both requesting: grant prio.
  - Otherwise with one requesting: grant that one.
- Acceptance:
  - mN_waitrequest = ~(grantN & ~reset_req).
  - Ungranted or idle master sees waitrequest high.
  - Requester must hold its signals stable until accepted.
- RAM drive: on acceptance, drive mem_* from the granted master in the same cycle. mem_chipselect is high only on acceptance.
- Throughput: one transfer per cycle, back-to-back, no bubbles.
- Read return:
  - Registered rd_pend (1 bit) and rd_tag (1 bit) are set on read acceptance.
  - Next cycle: mN_readdatavalid = rd_pend & (rd_tag==N).
  - mN_readdata = mem_readdata for both masters, qualified by valid.
  - Read latency exactly 1 cycle.
- prio update: after any unlocked acceptance, prio <= ~granted master. Fair alternation under contention.
- FSM states: IDLE/ARB (unlocked), LOCKED.
  - ARB -> LOCKED: accepted transfer with mN_lock=1; lock owner L <= N; lock_cnt <= 1.
  - LOCKED: each cycle lock_cnt++ (saturating).
  - LOCKED -> ARB: accepted transfer from L with mL_lock=0.
  - LOCKED -> ARB: lock_cnt reaches LOCK_MAX. Forced release; lock_to sticky flag set, cleared by reset only. The owner's lock is ignored until it issues a transfer with lock=0.
  - In LOCKED the other master waits regardless of prio.
  - LOCKED -> ARB release sets prio to the non-owner.
- reset_req:
  - All waitrequest high; mem_chipselect low; mem_clken low.
  - Lock state and counter hold.
  - A read accepted the cycle before still returns its readdatavalid.
- Reset (async, reset_n low):
  - prio=0, state ARB, lock_cnt=0, rd_pend=0, lock_to=0.
  - Outputs: both readdatavalid 0, both waitrequest 1 (no requests), mem_chipselect 0, mem_write 0.
  - Reset mid-read drops the pending readdatavalid.
- Internal status only: lock_to, exported through a debug hierarchy path; no port.

Decomposition:
- Package soc_mem_arb_pkg holds:
  - state enum {ARB, LOCKED};
  - master-index typedef (1 bit);
  - default width constants.
- One natural sub-module: soc_mem_arb_rr2, the 2-way round-robin grant with lock override (combinational grant plus registered prio).
- Datapath muxing and read-tag tracking stay in the top module.

Test Plan:
- Solo read: m0_read addr 0x0010 -> m0_waitrequest low same cycle. mem_address=0x0010, chipselect=1. Next cycle m0_readdatavalid=1 with RAM contents. m1 silent throughout.
- Contention after reset: m0 and m1 write continuously, 4 transfers each to addrs 0x100..0x103 / 0x200..0x203. Required:
  - grants alternate m0,m1,m0,m1,...;
  - 8 accepts in 8 cycles;
  - memory holds all values.
- Back-to-back reads both masters: readback returns each word to the correct master, 1 cycle after its accept, never to the other.
- Lock RMW:
  - m0 read 0x40 lock=1, then write 0x40 lock=0, while m1 requests continuously.
  - m1 blocked until m0's write is accepted, then granted next cycle.
- Lock timeout with LOCK_MAX=8: m1 reads with lock=1 then idles. Forced release after 8 cycles, lock_to=1, m0 granted at once.
- reset_req and reset:
  - reset_req mid-stream -> all waitrequest high, mem_clken=0; resume on deassert.
  - reset_n pulsed with read pending -> no readdatavalid; prio=0.
